// File: rtl/lcd_char_driver.sv
// Drives a 16x2 HD44780-style LCD in 8-bit write-only mode: power-up wait,
// init command sequence, then continuous refresh of both rows from line1/line2.
module lcd_char_driver #(
    parameter int TICK_DIV   = 50,
    parameter int POWERUP_US = 15000,
    parameter int CMD_US     = 40,
    parameter int CLEAR_US   = 1640
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] line1,
    input  logic [127:0] line2,
    input  logic         reinit,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data,
    output logic         init_done,
    output logic         frame_done
);

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WMAX = (POWERUP_US > CLEAR_US) ?
                          ((POWERUP_US > CMD_US) ? POWERUP_US : CMD_US) :
                          ((CLEAR_US > CMD_US) ? CLEAR_US : CMD_US);
    localparam int WW   = $clog2(WMAX + 1);

    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] ONE_P   = PW'(1);
    localparam logic [WW-1:0] PWR_LD  = WW'(POWERUP_US);
    localparam logic [WW-1:0] CMD_LD  = WW'(CMD_US);
    localparam logic [WW-1:0] CLR_LD  = WW'(CLEAR_US);
    localparam logic [WW-1:0] ONE_W   = WW'(1);

    typedef enum logic [2:0] {
        PWRUP, INIT, SNAP, ADDR1, ROW1, ADDR2, ROW2, FDONE
    } main_t;

    typedef enum logic [1:0] {
        B_IDLE, B_SETUP, B_PULSE, B_HOLD
    } byte_t;

    main_t          state;
    byte_t          bstate;
    logic [PW-1:0]  presc;
    logic [WW-1:0]  wait_cnt;
    logic [1:0]     init_idx;
    logic [3:0]     col;
    logic [127:0]   shadow1;
    logic [127:0]   shadow2;
    logic           reinit_pend;

    logic           tick;
    logic           act;
    logic           byte_end;
    logic           restart;
    logic [3:0]     col_sel;
    logic [127:0]   row_src;
    logic [7:0]     char_nxt;
    logic [7:0]     init_nxt;

    assign lcd_rw = 1'b0;

    // SNAP can coincide with the 0x80 strobe when TICK_DIV=1, so an immediate
    // restart there is held off while lcd_e is high and waits for the byte end.
    always_comb begin
        tick     = (presc == PRE_MAX);
        act      = reinit | reinit_pend;
        byte_end = (bstate == B_HOLD) && tick && (wait_cnt <= ONE_W);
        restart  = act && ((state == PWRUP) || (state == SNAP && !lcd_e) || byte_end);
    end

    // Next character: column 0 right after an address byte, else the next column.
    always_comb begin
        col_sel  = (state == ROW1 || state == ROW2) ? col + 4'd1 : 4'd0;
        row_src  = (state == ADDR2 || state == ROW2) ? shadow2 : shadow1;
        char_nxt = row_src[{~col_sel, 3'b000} +: 8];
        case (init_idx)
            2'd0:    init_nxt = 8'h0C;
            2'd1:    init_nxt = 8'h06;
            default: init_nxt = 8'h01;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= PWRUP;
            bstate      <= B_IDLE;
            presc       <= '0;
            wait_cnt    <= PWR_LD;
            init_idx    <= 2'd0;
            col         <= 4'd0;
            shadow1     <= '0;
            shadow2     <= '0;
            reinit_pend <= 1'b0;
            lcd_e       <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_data    <= 8'h00;
            init_done   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            presc      <= tick ? '0 : presc + ONE_P;
            if (reinit) reinit_pend <= 1'b1;

            if (restart) begin
                state       <= PWRUP;
                wait_cnt    <= PWR_LD;
                bstate      <= B_IDLE;
                init_done   <= 1'b0;
                lcd_e       <= 1'b0;
                lcd_rs      <= 1'b0;
                lcd_data    <= 8'h00;
                reinit_pend <= 1'b0;
            end else begin
                case (state)
                    PWRUP: if (tick) begin
                        if (wait_cnt <= ONE_W) begin
                            state    <= INIT;
                            init_idx <= 2'd0;
                            bstate   <= B_SETUP;
                            lcd_rs   <= 1'b0;
                            lcd_data <= 8'h38;
                        end else begin
                            wait_cnt <= wait_cnt - ONE_W;
                        end
                    end
                    SNAP: begin
                        shadow1 <= line1;
                        shadow2 <= line2;
                        state   <= ADDR1;
                    end
                    FDONE:   state <= SNAP;
                    default: ;
                endcase

                // Byte engine; every byte boundary falls on a tick.
                if (tick) begin
                    case (bstate)
                        B_SETUP: begin
                            bstate <= B_PULSE;
                            lcd_e  <= 1'b1;
                        end
                        B_PULSE: begin
                            bstate   <= B_HOLD;
                            lcd_e    <= 1'b0;
                            wait_cnt <= (state == INIT && init_idx == 2'd3) ? CLR_LD : CMD_LD;
                        end
                        B_HOLD: begin
                            if (wait_cnt > ONE_W) begin
                                wait_cnt <= wait_cnt - ONE_W;
                            end else begin
                                bstate <= B_SETUP;
                                case (state)
                                    INIT: begin
                                        lcd_rs <= 1'b0;
                                        if (init_idx == 2'd3) begin
                                            init_done <= 1'b1;
                                            state     <= SNAP;
                                            lcd_data  <= 8'h80;
                                        end else begin
                                            init_idx <= init_idx + 2'd1;
                                            lcd_data <= init_nxt;
                                        end
                                    end
                                    ADDR1, ADDR2: begin
                                        state    <= (state == ADDR1) ? ROW1 : ROW2;
                                        col      <= 4'd0;
                                        lcd_rs   <= 1'b1;
                                        lcd_data <= char_nxt;
                                    end
                                    ROW1, ROW2: begin
                                        if (col == 4'd15) begin
                                            lcd_rs <= 1'b0;
                                            if (state == ROW1) begin
                                                state    <= ADDR2;
                                                lcd_data <= 8'hC0;
                                            end else begin
                                                state      <= FDONE;
                                                frame_done <= 1'b1;
                                                lcd_data   <= 8'h80;
                                            end
                                        end else begin
                                            col      <= col + 4'd1;
                                            lcd_rs   <= 1'b1;
                                            lcd_data <= char_nxt;
                                        end
                                    end
                                    default: bstate <= B_IDLE;
                                endcase
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_char_driver.sv
// Bench for lcd_char_driver: a timeline model of the expected LCD byte stream
// (per-cycle strobe, bus, init_done, frame_done) plus a TICK_DIV=4 timing instance.
module tb_lcd_char_driver;

    localparam int POWERUP = 10;
    localparam int CMD     = 2;
    localparam int CLEAR   = 5;
    localparam int TD4     = 4;
    localparam logic [7:0] INIT_CMDS [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] line1, line2;
    logic         reinit;
    logic         reinit4;
    logic         lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
    logic [7:0]   lcd_data;
    logic         lcd_e4, lcd_rs4, lcd_rw4, init_done4, frame_done4;
    logic [7:0]   lcd_data4;

    always #5 clk = ~clk;

    lcd_char_driver #(.TICK_DIV(1), .POWERUP_US(POWERUP), .CMD_US(CMD), .CLEAR_US(CLEAR)) dut (
        .clk(clk), .rst(rst), .line1(line1), .line2(line2), .reinit(reinit),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
        .init_done(init_done), .frame_done(frame_done)
    );

    lcd_char_driver #(.TICK_DIV(TD4), .POWERUP_US(POWERUP), .CMD_US(CMD), .CLEAR_US(CLEAR)) dut4 (
        .clk(clk), .rst(rst), .line1(line1), .line2(line2), .reinit(reinit4),
        .lcd_e(lcd_e4), .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_data(lcd_data4),
        .init_done(init_done4), .frame_done(frame_done4)
    );

    // Scoreboard: expected {rs,data} per strobe and the cycle it must appear in.
    logic [8:0] exp_q[$];
    int         exp_t[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n;
    logic       exp_id;
    int         id_set_t, id_clr_t, fd_t;
    logic [8:0] last_b;
    int         last_pulse, last_end;
    int         frame_no, pos, rnd_pos, chg_pos, pwr_m;
    logic       d4_prev;
    int         d4_rises, d4_rise_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    function automatic int hold_of(input logic [8:0] b);
        return (b == 9'h001) ? CLEAR : CMD;
    endfunction

    function automatic logic [127:0] rand_line();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'($urandom_range(32, 126));
        return r;
    endfunction

    task automatic push_byte(inout int t, input logic [8:0] b);
        exp_q.push_back(b);
        exp_t.push_back(t + 1);
        t += 2 + hold_of(b);
    endtask

    task automatic gen_init(input int t0);
        int t;
        t = t0 + POWERUP;
        for (int i = 0; i < 4; i++) push_byte(t, {1'b0, INIT_CMDS[i]});
    endtask

    task automatic gen_frame(input int t0);
        int t;
        t = t0;
        push_byte(t, 9'h080);
        for (int c = 0; c < 16; c++) push_byte(t, {1'b1, line1[127-8*c -: 8]});
        push_byte(t, 9'h0C0);
        for (int c = 0; c < 16; c++) push_byte(t, {1'b1, line2[127-8*c -: 8]});
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_t.delete();
        gen_init(0);
        n = 0; exp_id = 1'b0; id_set_t = -1; id_clr_t = -1; fd_t = -1;
        last_b = '0; last_pulse = -1; last_end = 0;
        frame_no = 0; pos = 0; chg_pos = -1; pwr_m = -1;
        d4_prev = 1'b0; d4_rises = 0; d4_rise_t = 0;
    endtask

    task automatic model_reinit(input int t0, input int clr_t);
        exp_q.delete();
        exp_t.delete();
        gen_init(t0);
        fd_t = -1;
        if (clr_t >= 0) id_clr_t = clr_t;
    endtask

    task automatic stimulus_on_byte(input logic [8:0] b);
        if (b == 9'h080 && (frame_no == 4 || frame_no >= 6)) chg_pos = $urandom_range(1, 31);
        if (frame_no == 1 && pos == 6) line1 = {16{8'h58}};
        if (frame_no == 2 && pos == 10) begin
            line1 = rand_line();
            line2 = rand_line();
        end
        if (pos == chg_pos && (frame_no == 4 || frame_no >= 6)) begin
            line1 = rand_line();
            line2 = rand_line();
        end
        if ((frame_no == 3 && pos == 23) || (frame_no == 5 && pos == rnd_pos)) begin
            reinit = 1'b1;
            model_reinit(last_end, last_end);
            if (frame_no == 5) pwr_m = last_end + $urandom_range(0, 8);
        end
    endtask

    task automatic step(input bit events_on);
        logic       exp_e;
        logic [8:0] b;
        @(negedge clk);
        n++;
        reinit = 1'b0;
        if (n == id_set_t) exp_id = 1'b1;
        if (n == id_clr_t) exp_id = 1'b0;
        exp_e = (exp_t.size() > 0) && (exp_t[0] == n);
        check_eq("lcd_e", lcd_e, exp_e);
        check_eq("lcd_rw", lcd_rw, 1'b0);
        check_eq("init_done", init_done, exp_id);
        check_eq("frame_done", frame_done, n == fd_t);
        if (exp_t.size() > 0 && exp_t[0] == n + 1)
            check_eq("setup_bus", {lcd_rs, lcd_data}, exp_q[0]);
        else if (n > last_pulse && n < last_end)
            check_eq("hold_bus", {lcd_rs, lcd_data}, last_b);
        if (exp_e) begin
            b = exp_q.pop_front();
            void'(exp_t.pop_front());
            check_eq("pulse_bus", {lcd_rs, lcd_data}, b);
            last_b = b;
            last_pulse = n;
            last_end = n + 1 + hold_of(b);
            if (b == 9'h080) begin
                frame_no++;
                pos = 0;
            end else begin
                pos++;
            end
            if (exp_q.size() == 0) begin
                if (b == 9'h001) id_set_t = last_end;
                else fd_t = last_end;
                gen_frame(last_end);
            end
            if (events_on) stimulus_on_byte(b);
        end
        if (events_on && n == pwr_m) begin
            reinit = 1'b1;
            model_reinit(n + 1, -1);
        end
        // TICK_DIV=4 instance: strobe start time, width and bus for the init bytes.
        if (lcd_e4 && !d4_prev) begin
            if (d4_rises < 4) begin
                check_eq("d4_rise_time", n, TD4 * (POWERUP + 1 + (2 + CMD) * d4_rises));
                check_eq("d4_bus", {lcd_rs4, lcd_data4}, {1'b0, INIT_CMDS[d4_rises]});
            end
            d4_rise_t = n;
            d4_rises++;
        end
        if (!lcd_e4 && d4_prev && d4_rises <= 4) check_eq("d4_e_width", n - d4_rise_t, TD4);
        d4_prev = lcd_e4;
    endtask

    task automatic check_outputs_reset(input string tag);
        check_eq({tag, "_lcd_e"}, lcd_e, 1'b0);
        check_eq({tag, "_lcd_rs"}, lcd_rs, 1'b0);
        check_eq({tag, "_lcd_rw"}, lcd_rw, 1'b0);
        check_eq({tag, "_lcd_data"}, lcd_data, 8'h00);
        check_eq({tag, "_init_done"}, init_done, 1'b0);
        check_eq({tag, "_frame_done"}, frame_done, 1'b0);
        check_eq({tag, "_d4_lcd_e"}, lcd_e4, 1'b0);
        check_eq({tag, "_d4_lcd_rs"}, lcd_rs4, 1'b0);
        check_eq({tag, "_d4_lcd_data"}, lcd_data4, 8'h00);
        check_eq({tag, "_d4_init_done"}, init_done4, 1'b0);
    endtask

    initial begin
        logic found;
        rst     = 1'b0;
        reinit  = 1'b0;
        reinit4 = 1'b0;
        line1   = "PRESS * TO START";
        line2   = "MONEY: 01000    ";
        rnd_pos = $urandom_range(0, 33);
        n       = 0;
        repeat (3) @(negedge clk);
        check_outputs_reset("reset");

        rst = 1'b1;
        model_reset();
        repeat (2000) step(1'b1);

        // Asynchronous reset in the middle of a strobe.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (lcd_e) found = 1'b1;
        end
        check_eq("strobe_seen_before_reset", found, 1'b1);
        #2 rst = 1'b0;
        #1 check_outputs_reset("async_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (400) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_char_driver.md
Name: lcd_char_driver

Overview:
- Sequences a 16x2 HD44780-compatible character LCD in 8-bit write-only mode.
- Performs the power-up wait and the controller init command sequence.
- Then continuously refreshes both display rows from the 128-bit line1/line2 text buffers produced by the game's display-text block.
- Sits between the text generator and the board's LCD pins; it is the only block that drives the LCD bus.

Parameters:
TICK_DIV, 50, clk cycles per timing tick (50 gives 1 us at 50 MHz)
POWERUP_US, 15000, ticks to wait after reset before the first command
CMD_US, 40, HOLD ticks after every command/data write except clear
CLEAR_US, 1640, HOLD ticks after the clear-display command (0x01)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (rst=0 resets)
line1  input  128  row-0 text; bits [127:120] = column 0, [7:0] = column 15, ASCII
line2  input  128  row-1 text, same packing
reinit  input  1  single-cycle pulse; restarts the power-up/init sequence
lcd_e  output  1  LCD enable strobe
lcd_rs  output  1  0 = command, 1 = data
lcd_rw  output  1  constant 0 (write only)
lcd_data  output  8  LCD data bus
init_done  output  1  high once the init sequence has completed
frame_done  output  1  one-cycle pulse after the last byte of each refresh frame

Behaviour:
- Reset (rst=0, async): lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, init_done=0, frame_done=0, prescaler=0, main FSM=PWRUP, wait counter=POWERUP_US.
- Tick: prescaler counts 0..TICK_DIV-1; tick=1 for one clk when prescaler==TICK_DIV-1. All timing state advances only on tick.
- Main FSM states:
  - PWRUP: counts POWERUP_US ticks, then goes to INIT.
  - INIT: issues 0x38, 0x0C, 0x06, 0x01 in order, all with RS=0. Clear uses CLEAR_US hold; the others use CMD_US.
  - SNAP: taken after the last init byte's HOLD. Sets init_done=1 and goes to SNAP, which captures line1/line2 into internal shadow registers in one clk.
  - ADDR1: writes 0x80, RS=0.
  - ROW1: writes shadow1 columns 0..15, RS=1.
  - ADDR2: writes 0xC0, RS=0.
  - ROW2: writes shadow2 columns 0..15, RS=1.
  - FDONE: frame_done=1 for exactly one clk, then returns to SNAP. Refresh is continuous.
- Byte-write sub-FSM: per byte, entered with lcd_rs/lcd_data driven.
  - SETUP: lasts 1 tick period, lcd_e=0.
  - PULSE: lasts 1 tick period, lcd_e=1.
  - HOLD: lcd_e=0, lasts N ticks (N = CMD_US or CLEAR_US), then the next byte starts.
  - Byte time = (2+N) ticks.
  - lcd_rs/lcd_data are stable from SETUP entry through HOLD exit.
- Frame: 34 bytes (2 address + 32 characters). Input changes mid-frame do not affect the current frame; shadows update only in SNAP.
- Column index: 4-bit counter, 0..15. Wrap from 15 advances the state (ROW1->ADDR2, ROW2->FDONE).
- reinit:
  - Sampled any cycle and latched as pending.
  - Acted on at the next byte boundary (HOLD exit), or immediately if in PWRUP or SNAP.
  - Action: init_done=0, FSM=PWRUP with wait reload. lcd_e is never cut short mid-pulse.
  - reinit during PWRUP restarts the wait.
- rst asserted mid-byte: all outputs return to reset values asynchronously, including lcd_e=0.
- lcd_rw is tied 0; no busy-flag read.

Test Plan:
- TICK_DIV=1, POWERUP_US=10, CMD_US=2, CLEAR_US=5; release rst.
  - lcd_e stays 0 for 10 clks.
  - Then bytes 0x38, 0x0C, 0x06 with RS=0, each 4 clks, lcd_e high in the 2nd clk of each.
  - 0x01 occupies 7 clks.
  - init_done rises at clk 29 after reset release.
- Same config, line1="PRESS * TO START", line2="MONEY: 01000    ".
  - Captured bus shows 0x80, 'P'..'T' (RS=1), 0xC0, 'M'..' ' (RS=1).
  - frame_done pulses once per 136 clks.
- Change line1 to all 'X' midway through ROW1.
  - Current frame completes with the old text.
  - The following frame shows 16 'X'.
- Pulse reinit during ROW2 column 5.
  - Column-5 byte completes its full HOLD.
  - lcd_e then stays 0 for 10 clks and the init sequence re-runs; init_done drops to 0 and rises again.
- TICK_DIV=4: verify lcd_e high exactly 4 clks per byte and byte period (2+2)*4=16 clks; tick count resets on rst.
- Assert rst while lcd_e=1: lcd_e, lcd_rs, and lcd_data go to 0 without waiting for clk; after release, PWRUP restarts from the full count.
